led_sequencer: RTL
==================

LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 SHALL have parameter N, default 6: LED count, legal 1..32.
REQ-002 SHALL have parameter CNT_W, default 32: width of period counter and period input.
REQ-003 SHALL have parameter PERIOD_DEFAULT, default 32'hffff_ffff (truncated to CNT_W): period in force after reset.
REQ-004 SHALL have parameter PWM_W, default 8: PWM counter and duty width.
REQ-005 SHALL have one clock; reset is synchronous and active-high. Ports: clk  in  1  rising-edge clock.
REQ-006 SHALL have port reset  in  1  synchronous active-high reset.
REQ-007 SHALL have port en  in  1  high = sequencer advances; low = pattern and period counter freeze.
REQ-008 SHALL have port mode  in  2  00 rotate-left, 01 rotate-right, 10 bounce, 11 blink; sampled only on mode_load.
REQ-009 SHALL have port period  in  CNT_W  step interval minus one, in clocks; sampled only on mode_load.
REQ-010 SHALL have port mode_load  in  1  single-cycle strobe; latches mode and period and restarts the sequence.
REQ-011 SHALL have port duty  in  PWM_W  brightness; present only when LED_PWM_EN is defined.
REQ-012 SHALL have port led  out  N  registered LED drive.
REQ-013 SHALL have port step  out  1  registered one-cycle pulse, high in the cycle the pattern has just advanced.

Function
REQ-014 SHALL hold internal registers mode_q, period_q, cnt (CNT_W), pattern (N), dir (0 up, 1 down).
REQ-015 SHALL, when en=1 and no load, set cnt to 0 if cnt==period_q, else to cnt+1; period_q=0 gives a step every clock.
REQ-016 SHALL advance the pattern and pulse step on the edge where en=1, cnt==period_q and mode_load=0.
REQ-017 SHALL rotate-left in mode 00: bit N-1 wraps to bit 0.
REQ-018 SHALL rotate-right in mode 01: bit 0 wraps to bit N-1.
REQ-019 SHALL bounce in mode 10: shift up while dir=0; reverse at bit N-1 (next step goes to N-2) and at bit 0; the end bits occur once per sweep.
REQ-020 SHALL invert every pattern bit on each step in mode 11.
REQ-021 SHALL use initial patterns 00: bit 0; 01: bit N-1; 10: bit 0 with dir=0; 11: all ones.
REQ-022 SHALL, on mode_load=1 regardless of en, latch mode_q/period_q, clear cnt, load the initial pattern and suppress step that cycle; load wins over a coincident step.
REQ-023 SHALL, in modes 00-10, replace an all-zero pattern with the mode's initial pattern on the next clock independent of en.
REQ-024 SHALL, for N=1, keep bit 0 set in modes 00-10 and toggle it in mode 11.
REQ-025 SHALL hold pattern, cnt, dir while en=0 and not loading; step=0.
REQ-026 SHALL drive led = pattern with one register stage and no combinational path from inputs.

Reset
REQ-027 SHALL on reset set cnt=0, mode_q=00, period_q=PERIOD_DEFAULT, pattern=1, dir=0, step=0, led=1, PWM counter=0.
REQ-028 SHALL give reset priority over mode_load and en; reset mid-sequence restarts from REQ-027 on the next clock.

Configuration
REQ-029 SHALL use macro LED_PWM_EN to compile in dimming: free-running PWM_W counter; led = pattern gated by (pwm_cnt < duty).
REQ-030 SHALL, with LED_PWM_EN, give duty=0 fully dark and duty=2^PWM_W-1 on for 2^PWM_W-1 of every 2^PWM_W clocks; step timing unaffected.
REQ-031 SHALL, without LED_PWM_EN, omit duty and the PWM counter; led = pattern.

Verification (N=6)
REQ-032 SHALL cover load mode 00, period 3, en=1 -> led 1,2,4,8,16,32,1, each held 4 clocks, step once per 4 clocks.
REQ-033 SHALL cover mode 10, period 0 -> led 1,2,4,8,16,32,16,8,4,2,1,2 on consecutive clocks.
REQ-034 SHALL cover mode 11, period 1 -> led 63,0,63,0 every 2 clocks; then mode_load to 01 coincident with a step -> led 32, step=0 that cycle.
REQ-035 SHALL cover en dropped 2 clocks mid-interval -> led and cnt frozen, step delayed exactly 2 clocks; reset mid-sequence -> led=1, cnt=0, mode 00, period PERIOD_DEFAULT.
REQ-036 SHALL cover, with LED_PWM_EN, PWM_W=8, duty 64, pattern 1 -> led[0] high exactly 64 of each 256 clocks; duty 0 -> led all 0.

Source files
------------

// File: rtl/led_sequencer.sv
// LED pattern sequencer: rotate-left/right, bounce and blink patterns stepped every period_q+1 clocks.
// Optional dimming is compiled in with `define LED_PWM_EN (adds the duty port and a free-running PWM counter).
module led_sequencer #(
  parameter int          N              = 6,
  parameter int          CNT_W          = 32,
  parameter logic [31:0] PERIOD_DEFAULT = 32'hffff_ffff,
  parameter int          PWM_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] period,
  input  logic             mode_load,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0] duty,
`endif
  output logic [N-1:0]     led,
  output logic             step
);

  localparam logic [1:0] MODE_ROL    = 2'b00;
  localparam logic [1:0] MODE_ROR    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_BLINK  = 2'b11;

  logic [1:0]       mode_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     pattern;
  logic             dir;

  logic [1:0]       mode_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [N-1:0]     pattern_nxt;
  logic             dir_nxt;
  logic             step_nxt;
  logic             hit;
  logic [N:0]       adv;

  function automatic logic [N-1:0] init_pattern(input logic [1:0] m);
    logic [N-1:0] p;
    case (m)
      MODE_ROL:    p = N'(1);
      MODE_ROR:    p = N'(1) << (N - 1);
      MODE_BOUNCE: p = N'(1);
      MODE_BLINK:  p = '1;
      default:     p = N'(1);
    endcase
    return p;
  endfunction

  // Returns {next dir, next pattern} for one step in mode m.
  function automatic logic [N:0] advance(input logic [1:0] m, input logic [N-1:0] p, input logic d);
    logic [N-1:0] np;
    logic         nd;
    np = p;
    nd = d;
    case (m)
      MODE_ROL:    np = (p << 1) | (p >> (N - 1));
      MODE_ROR:    np = (p >> 1) | (p << (N - 1));
      MODE_BOUNCE: begin
        if (N == 1) begin
          np = p | N'(1);
          nd = 1'b0;
        end else if (!d) begin
          np = p << 1;
          nd = np[N-1];
        end else begin
          np = p >> 1;
          nd = ~np[0];
        end
      end
      MODE_BLINK:  np = ~p;
      default:     np = p;
    endcase
    return {nd, np};
  endfunction

  assign hit = (cnt == period_q);
  assign adv = advance(mode_q, pattern, dir);

  // Next-state selection: load beats zero-recovery, which beats a normal step.
  always_comb begin
    mode_nxt    = mode_q;
    period_nxt  = period_q;
    cnt_nxt     = cnt;
    pattern_nxt = pattern;
    dir_nxt     = dir;
    step_nxt    = 1'b0;
    if (mode_load) begin
      mode_nxt    = mode;
      period_nxt  = period;
      cnt_nxt     = '0;
      pattern_nxt = init_pattern(mode);
      dir_nxt     = 1'b0;
    end else begin
      if (en) begin
        cnt_nxt  = hit ? '0 : cnt + CNT_W'(1);
        step_nxt = hit;
      end else begin
        cnt_nxt  = cnt;
        step_nxt = 1'b0;
      end
      // An empty pattern would never light again in the shifting modes.
      if (mode_q != MODE_BLINK && pattern == '0) begin
        pattern_nxt = init_pattern(mode_q);
        dir_nxt     = 1'b0;
      end else if (en && hit) begin
        pattern_nxt = adv[N-1:0];
        dir_nxt     = adv[N];
      end else begin
        pattern_nxt = pattern;
        dir_nxt     = dir;
      end
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= MODE_ROL;
      period_q <= CNT_W'(PERIOD_DEFAULT);
      cnt      <= '0;
      pattern  <= N'(1);
      dir      <= 1'b0;
      step     <= 1'b0;
      led      <= N'(1);
`ifdef LED_PWM_EN
      pwm_cnt  <= '0;
`endif
    end else begin
      mode_q   <= mode_nxt;
      period_q <= period_nxt;
      cnt      <= cnt_nxt;
      pattern  <= pattern_nxt;
      dir      <= dir_nxt;
      step     <= step_nxt;
`ifdef LED_PWM_EN
      pwm_cnt  <= pwm_cnt + PWM_W'(1);
      led      <= (pwm_cnt < duty) ? pattern_nxt : '0;
`else
      led      <= pattern_nxt;
`endif
    end
  end

endmodule
